// File: rtl/present80_pkg.sv
// Shared constants and types for the iterative PRESENT-80 encryption core.
package present80_pkg;

    localparam int KEY_W   = 80;
    localparam int BLOCK_W = 64;
    localparam int RC_W    = 6;
    localparam int ROUNDS  = 31;

    // Entry n of the packed array is S(n); the rightmost literal is S(0).
    localparam logic [15:0][3:0] SBOX = {
        4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
        4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
    };

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/present80_sbox.sv
// 4-bit PRESENT substitution box, purely combinational.
module present80_sbox
    import present80_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/present80_core.sv
// PRESENT-80 encryption engine: one round per clock, 32 cycles from accepted start to done.
module present80_core
    import present80_pkg::*;
#(
    parameter int ROUNDS = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KEY_W-1:0]     key,
    input  logic [BLOCK_W-1:0]   plaintext,
    output logic [BLOCK_W-1:0]   ciphertext,
    output logic                 busy,
    output logic                 done
);

    state_e               fsm_q, fsm_d;
    logic [BLOCK_W-1:0]   state_q, state_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic [RC_W-1:0]      rc_q, rc_d;
    logic [BLOCK_W-1:0]   ct_d;
    logic                 busy_d, done_d;

    logic [BLOCK_W-1:0]   round_in;
    logic [BLOCK_W-1:0]   sb_out;
    logic [BLOCK_W-1:0]   perm;
    logic [KEY_W-1:0]     key_rot;
    logic [3:0]           key_sb;
    logic [KEY_W-1:0]     key_next;

    assign round_in = state_q ^ key_q[KEY_W-1:KEY_W-BLOCK_W];

    for (genvar n = 0; n < 16; n++) begin : g_sbox
        present80_sbox u_sbox (
            .din  (round_in[4*n +: 4]),
            .dout (sb_out[4*n +: 4])
        );
    end

    // Bit i lands at (16*i) mod 63; bit 63 is a fixed point.
    for (genvar i = 0; i < BLOCK_W - 1; i++) begin : g_player
        assign perm[(16 * i) % 63] = sb_out[i];
    end
    assign perm[BLOCK_W-1] = sb_out[BLOCK_W-1];

    assign key_rot = {key_q[18:0], key_q[79:19]};

    present80_sbox u_key_sbox (
        .din  (key_rot[79:76]),
        .dout (key_sb)
    );

    assign key_next = {key_sb, key_rot[75:20], key_rot[19:15] ^ rc_q[4:0], key_rot[14:0]};

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        ct_d    = ciphertext;
        busy_d  = busy;
        done_d  = 1'b0;

        unique case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d = plaintext;
                    key_d   = key;
                    rc_d    = RC_W'(1);
                    busy_d  = 1'b1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                if (rc_q == RC_W'(ROUNDS + 1)) begin
                    ct_d   = round_in;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    rc_d   = '0;
                    fsm_d  = IDLE;
                end else begin
                    state_d = perm;
                    key_d   = key_next;
                    rc_d    = rc_q + RC_W'(1);
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q      <= IDLE;
            state_q    <= '0;
            key_q      <= '0;
            rc_q       <= '0;
            ciphertext <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            key_q      <= key_d;
            rc_q       <= rc_d;
            ciphertext <= ct_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: doc/present80_core.md
# present80_core

Iterative PRESENT-80 block-cipher encryption engine that consumes the key, plaintext and start control held in the Wishbone register file and returns the 64-bit ciphertext for its CMOS_OUT read-back registers. One cipher round executes per clock; a full encryption takes 32 cycles from an accepted start to a one-cycle done pulse. The core sits directly downstream of the Wishbone slave and is agnostic to bus timing.

## Interface
Parameters:
- ROUNDS, 31, number of full rounds before final key whitening; fixed by the cipher and not overridden in this design.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request encryption; sampled only while busy=0.
- key  input  80  cipher key, bit 79 = MSB; sampled on the accepted start edge only.
- plaintext  input  64  plaintext block, bit 63 = MSB; sampled on the accepted start edge only.
- ciphertext  output  64  result register; updated only on completion, held otherwise.
- busy  output  1  high while a block is in flight.
- done  output  1  single-cycle pulse, coincident with the first cycle ciphertext is valid.

## Operation
- States: IDLE, RUN. Reset forces IDLE, round counter 0, state/key registers 0, ciphertext=0, busy=0, done=0.
- IDLE: on start=1 at a clock edge, load state<=plaintext, keyreg<=key, rc<=1, go RUN, busy<=1.
- RUN, rc in 1..31, per edge: s = state ^ keyreg[79:16]; s = S-box on all 16 nibbles; s = pLayer(s); state<=s; keyreg<=update(keyreg, rc); rc<=rc+1.
- After the edge with rc=31 processed, rc=32: next edge registers ciphertext<=state ^ keyreg[79:16], done<=1, busy<=0, rc<=0, go IDLE.
- S-box (hex, input 0..F): C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
- pLayer: bit i moves to position (16*i) mod 63 for i in 0..62; bit 63 stays.
- Key update: k = k rotated left by 61 (k = {k[18:0], k[79:19]}); k[79:76] = S(k[79:76]); k[19:15] ^= rc[4:0].
- rc is 6 bits; values above 32 never occur.
- start while busy=1 is ignored; no queuing. key/plaintext changes after acceptance have no effect on the running block.
- done is a pulse, deasserted the following cycle unconditionally.

## Timing
- Start sampled at edge E0; rounds at E1..E31; ciphertext/done registered at E32. done high for the cycle after E32; latency 32 cycles.
- busy rises after E0, falls after E32 (same cycle done rises).
- start high during the done cycle is accepted at E33: back-to-back throughput one block per 33 cycles.
- Reset asserted mid-RUN: next edge returns all registers to reset values; no done pulse for the aborted block; ciphertext reads 0.
- reset and start together: reset wins.

## Structure
- Package present80_pkg: SBOX constant (16x4), ROUNDS=31, KEY_W=80, BLOCK_W=64, RC_W=6, state enum {IDLE, RUN}.
- Sub-module present80_sbox: 4-bit combinational lookup, instanced 16x for the data path and 1x for the key schedule.
- pLayer is pure wiring in a generate loop inside the core.

## Test plan
- key=0, plaintext=0, pulse start -> done exactly 32 cycles later, ciphertext=0x5579C1387B228445.
- key=0xFFFFFFFFFFFFFFFFFFFF, plaintext=0 -> ciphertext=0xE72C46C0F5945049.
- key=0, plaintext=0xFFFFFFFFFFFFFFFF -> ciphertext=0xA112FFC72F68417B; then key/plaintext all-ones started in the done cycle -> accepted, ciphertext=0x3333DCD3213210D2 33 cycles after first done.
- Start with all-zero vectors, then pulse start and change key/plaintext to all-ones at cycle 10 -> single done at cycle 32, ciphertext=0x5579C1387B228445, busy never drops early.
- Start, assert reset at cycle 15 for one cycle -> busy=0, done never pulses, ciphertext=0; subsequent start completes normally.
- Hold start high continuously for 100 cycles with zero vectors -> done pulses at cycles 32 and 65, busy low only during the done cycles.
